// File: rtl/miss_handler_mem.sv
// Main-memory stage behind the L1: optional victim write-back, then line fill, one miss at a time.
// Latency LATENCY (clean) or 2*LATENCY (dirty) cycles from accept to ack; req is ignored while busy.
module miss_handler_mem #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 8,
  parameter int LATENCY = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req,
  input  logic              wb,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [ADDR_W-1:0] fill_addr,
  output logic              ack,
  output logic [DATA_W-1:0] fill_data,
  output logic              busy,
  output logic [7:0]        wb_count,
  output logic [7:0]        fill_count
);

  typedef enum logic [1:0] {IDLE, WB, FILL, DONE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic              accept, wb_commit, fill_done;
  logic              wb_q;
  logic [ADDR_W-1:0] wb_addr_q, fill_addr_q;
  logic [DATA_W-1:0] wb_data_q;
  logic [DATA_W-1:0] mem_rd;

  // Storage holds the difference from the address pattern, so a zeroed array
  // reads back as mem[a] = a[7:0] without any reset or load sequence.
  logic [DATA_W-1:0] mem_delta [0:(1<<ADDR_W)-1];

  function automatic logic [DATA_W-1:0] addr_pattern(input logic [ADDR_W-1:0] a);
    return DATA_W'(a);
  endfunction

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    wb_commit = 1'b0;
    fill_done = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          accept    = 1'b1;
          cnt_nxt   = CNT_LOAD;
          state_nxt = wb ? WB : FILL;
        end
      end
      WB: begin
        if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          wb_commit = 1'b1;
          cnt_nxt   = CNT_LOAD;
          state_nxt = FILL;
        end
      end
      FILL: begin
        if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          fill_done = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign ack    = (state == DONE);
  assign busy   = (state != IDLE);
  assign mem_rd = mem_delta[fill_addr_q] ^ addr_pattern(fill_addr_q);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      wb_q        <= 1'b0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      fill_addr_q <= '0;
      fill_data   <= '0;
      wb_count    <= 8'd0;
      fill_count  <= 8'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        wb_q        <= wb;
        wb_addr_q   <= wb_addr;
        wb_data_q   <= wb_data;
        fill_addr_q <= fill_addr;
      end
      if (wb_commit) wb_count <= wb_count + 8'd1;
      if (fill_done) begin
        fill_data  <= mem_rd;
        fill_count <= fill_count + 8'd1;
      end
    end
  end

  // Memory contents survive reset; the commit happens on an edge strictly before
  // the fill read, so a same-address fill sees the victim data.
  always_ff @(posedge clock) begin
    if (wb_commit && wb_q) mem_delta[wb_addr_q] <= wb_data_q ^ addr_pattern(wb_addr_q);
  end

endmodule
